instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/mips_pkg.sv | 29 ++
 rtl/pc_next.sv | 46 ++++
 rtl/instruction_fetch.sv | 96 +++++++++
 tb/tb_instruction_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg
// Shared opcode constants, redirect encodings and fetch-state type.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;

    localparam logic [1:0] c_REDIR_NONE = 2'b00;
    localparam logic [1:0] c_REDIR_BNE  = 2'b01;
    localparam logic [1:0] c_REDIR_JUMP = 2'b10;
    localparam logic [1:0] c_REDIR_JR   = 2'b11;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next.sv
//------------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection: sequential, BNE, J/JAL or JR target.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] jr_target,
    output logic [31:0] pcPlus4,
    output logic [31:0] nextPc
);

    logic [31:0] w_bneTarget;
    logic [31:0] w_jumpTarget;
    logic [31:0] w_jrTarget;
    logic        w_unusedOpcode;

    assign pcPlus4        = pc + 32'd4;
    assign w_bneTarget    = pcPlus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_jumpTarget   = {pcPlus4[31:28], instr[25:0], 2'b00};
    assign w_jrTarget     = jr_target & 32'hFFFF_FFFC;
    assign w_unusedOpcode = ^instr[31:26];

    // The reserved encoding falls through to the sequential address.
    always_comb begin
        nextPc = pcPlus4;
        if (redirect_valid) begin
            case (redirect_type)
                c_REDIR_BNE:  nextPc = w_bneTarget;
                c_REDIR_JUMP: nextPc = w_jumpTarget;
                c_REDIR_JR:   nextPc = w_jrTarget;
                default:      nextPc = pcPlus4;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch
// Fetch FSM: requests a word at pc, holds it until consumed, then advances pc.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] jr_target
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  w_nextPc;
    logic [31:0]  w_pcPlus4;

    pc_next u_pcNext (
        .pc             (r_pc),
        .instr          (r_instr),
        .redirect_valid (redirect_valid),
        .redirect_type  (redirect_type),
        .jr_target      (jr_target),
        .pcPlus4        (w_pcPlus4),
        .nextPc         (w_nextPc)
    );

    // Reset wins over any same-cycle ack, dropping the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0000_0000;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == FETCH_REQ) && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if ((r_state == FETCH_HOLD) && instr_ready) begin
                r_pc <= w_nextPc;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                w_stateNext = FETCH_REQ;
            end
            FETCH_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_stateNext = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_stateNext = FETCH_REQ;
                end
            end
            default: begin
                w_stateNext = FETCH_IDLE;
            end
        endcase
    end

    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign opcode    = r_instr[31:26];
    assign pc_plus4  = w_pcPlus4;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// tb_instruction_fetch
// Directed vector table followed by randomized traffic against a reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] jr_target;

    int nChecks = 0;
    int nErr    = 0;

    instruction_fetch #(.RESET_PC(c_RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .opcode         (opcode),
        .pc_plus4       (pc_plus4),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_type  (redirect_type),
        .jr_target      (jr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        rv;
        logic [1:0]  rt;
        logic [31:0] jr;
        logic        eReq;
        logic        eValid;
        logic [31:0] eAddr;
        logic [31:0] eInstr;
        logic [31:0] eP4;
    } step_t;

    step_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic rv, input logic [1:0] rt, input logic [31:0] jr,
                       input logic eReq, input logic eValid, input logic [31:0] eAddr,
                       input logic [31:0] eInstr, input logic [31:0] eP4);
        step_t s;
        s.rst = rst; s.ack = ack; s.rdata = rdata; s.rdy = rdy; s.rv = rv; s.rt = rt; s.jr = jr;
        s.eReq = eReq; s.eValid = eValid; s.eAddr = eAddr; s.eInstr = eInstr; s.eP4 = eP4;
        tbl.push_back(s);
    endtask

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                         input logic rdy, input logic rv, input logic [1:0] rt, input logic [31:0] jr);
        reset          = rst;
        imem_ack       = ack;
        imem_rdata     = rdata;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_type  = rt;
        jr_target      = jr;
    endtask

    // Reference: the target address derived directly from the instruction-set rules.
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic rv, input logic [1:0] rt, input logic [31:0] jr);
        logic [31:0] p4;
        logic [31:0] off;
        p4  = pc + 32'd4;
        off = {{16{ins[15]}}, ins[15:0]};
        if (!rv)          return p4;
        if (rt == 2'b01)  return p4 + off * 32'd4;
        if (rt == 2'b10)  return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
        if (rt == 2'b11)  return jr & ~32'd3;
        return p4;
    endfunction

    // Model variables: mStartup marks the single quiet cycle after reset,
    // mHave marks that a fetched word is being offered downstream.
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic        mStartup;
    logic        mHave;

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        repeat (2) @(posedge clk);

        // Directed table: expected outputs in a cycle, then inputs for that cycle.
        add(0,1,32'hDEAD_BEEF,0,0,2'd0,32'h0,        0,0,32'h0,        32'h0,        32'h0);
        add(0,1,32'h2008_0005,0,0,2'd0,32'h0,        1,0,32'h0,        32'h0,        32'h0);
        add(0,1,32'hFFFF_FFFF,0,1,2'd2,32'h0,        0,1,32'h0,        32'h2008_0005,32'h4);
        for (int k = 0; k < 4; k++)
            add(0,0,32'h0,0,1,2'd3,32'h0,            0,1,32'h0,        32'h2008_0005,32'h4);
        add(0,0,32'h0,1,0,2'd0,32'h0,                0,1,32'h0,        32'h2008_0005,32'h4);
        for (int k = 0; k < 3; k++)
            add(0,0,32'h0,0,0,2'd0,32'h0,            1,0,32'h4,        32'h2008_0005,32'h0);
        add(1,1,32'h1111_1111,1,1,2'd2,32'h0,        1,0,32'h4,        32'h2008_0005,32'h0);
        add(0,0,32'h0,0,0,2'd0,32'h0,                0,0,32'h0,        32'h0,        32'h0);
        add(0,1,32'h0800_0010,0,0,2'd0,32'h0,        1,0,32'h0,        32'h0,        32'h0);
        add(0,0,32'h0,1,1,2'd2,32'h0,                0,1,32'h0,        32'h0800_0010,32'h4);
        add(0,1,32'h1509_FFFE,0,0,2'd0,32'h0,        1,0,32'h40,       32'h0800_0010,32'h0);
        add(0,0,32'h0,1,1,2'd1,32'h0,                0,1,32'h40,       32'h1509_FFFE,32'h44);
        add(0,1,32'h0000_0008,0,0,2'd0,32'h0,        1,0,32'h3C,       32'h1509_FFFE,32'h0);
        add(0,0,32'h0,1,1,2'd3,32'h123,              0,1,32'h3C,       32'h8,        32'h40);
        add(0,1,32'h0000_0008,0,0,2'd0,32'h0,        1,0,32'h120,      32'h8,        32'h0);
        add(0,0,32'h0,1,1,2'd3,32'h1000_0003,        0,1,32'h120,      32'h8,        32'h124);
        add(0,1,32'h0800_0010,0,0,2'd0,32'h0,        1,0,32'h1000_0000,32'h8,        32'h0);
        add(0,0,32'h0,1,1,2'd2,32'h0,                0,1,32'h1000_0000,32'h0800_0010,32'h1000_0004);
        add(0,1,32'h0000_0000,0,0,2'd0,32'h0,        1,0,32'h1000_0040,32'h0800_0010,32'h0);
        add(0,0,32'h0,1,1,2'd0,32'h0,                0,1,32'h1000_0040,32'h0,        32'h1000_0044);
        add(0,1,32'h0000_0008,0,0,2'd0,32'h0,        1,0,32'h1000_0044,32'h0,        32'h0);
        add(0,0,32'h0,1,1,2'd3,32'hFFFF_FFFE,        0,1,32'h1000_0044,32'h8,        32'h1000_0048);
        add(0,1,32'h2008_0005,0,0,2'd0,32'h0,        1,0,32'hFFFF_FFFC,32'h8,        32'h0);
        add(0,0,32'h0,1,0,2'd0,32'h0,                0,1,32'hFFFF_FFFC,32'h2008_0005,32'h0);
        add(0,0,32'h0,0,0,2'd0,32'h0,                1,0,32'h0,        32'h2008_0005,32'h0);

        foreach (tbl[i]) begin
            logic [31:0] ei;
            @(negedge clk);
            ei = tbl[i].eInstr;
            chk($sformatf("step%0d imem_req", i),    {31'd0, imem_req},    {31'd0, tbl[i].eReq});
            chk($sformatf("step%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].eValid});
            chk($sformatf("step%0d imem_addr", i),   imem_addr,            tbl[i].eAddr);
            chk($sformatf("step%0d instr", i),       instr,                ei);
            if (tbl[i].eValid) begin
                chk($sformatf("step%0d opcode", i),   {26'd0, opcode}, {26'd0, ei[31:26]});
                chk($sformatf("step%0d pc_plus4", i), pc_plus4,        tbl[i].eP4);
            end
            drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].rv, tbl[i].rt, tbl[i].jr);
        end

        // Randomized traffic against the reference model.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0);
        mPc = c_RESET_PC; mInstr = 32'h0; mStartup = 1'b1; mHave = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic        rst, ack, rdy, rv;
            logic [1:0]  rt;
            logic [31:0] rd, jr;
            @(negedge clk);
            chk("rand imem_req",    {31'd0, imem_req},    {31'd0, (!mStartup && !mHave)});
            chk("rand instr_valid", {31'd0, instr_valid}, {31'd0, mHave});
            chk("rand imem_addr",   imem_addr,            mPc);
            chk("rand instr",       instr,                mInstr);
            if (mHave) begin
                chk("rand opcode",   {26'd0, opcode}, {26'd0, mInstr[31:26]});
                chk("rand pc_plus4", pc_plus4,        mPc + 32'd4);
            end
            rst = ($urandom_range(0, 59) == 0);
            ack = $urandom_range(0, 1) == 1;
            rdy = $urandom_range(0, 2) != 0;
            rv  = $urandom_range(0, 1) == 1;
            rt  = 2'($urandom_range(0, 3));
            rd  = $urandom;
            jr  = $urandom;
            drive(rst, ack, rd, rdy, rv, rt, jr);
            if (rst) begin
                mPc = c_RESET_PC; mInstr = 32'h0; mStartup = 1'b1; mHave = 1'b0;
            end else if (mStartup) begin
                mStartup = 1'b0;
            end else if (!mHave) begin
                if (ack) begin
                    mInstr = rd;
                    mHave  = 1'b1;
                end
            end else if (rdy) begin
                mPc   = refNext(mPc, mInstr, rv, rt, jr);
                mHave = 1'b0;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

`default_nettype wire
